// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// ram_fifo_ctrl_pkg : shared widths and skid-buffer state type, rev 1.0
// ==========================================================================
package ram_fifo_ctrl_pkg;

    localparam int DEF_RAM_WIDTH     = 8;
    localparam int DEF_RAM_ADDR_BITS = 14;

    // Pointers carry one extra wrap bit; level must reach D+2 (RAM plus skid).
    function automatic int ptr_bits(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic int level_bits(input int addr_bits);
        return addr_bits + 2;
    endfunction

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ==========================================================================
// ram_fifo_ctrl_if : stream handshakes and RAM port bundle, rev 1.0
// ==========================================================================
interface ram_fifo_ctrl_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14
);
    import ram_fifo_ctrl_pkg::*;

    localparam int LEVEL_BITS = level_bits(RAM_ADDR_BITS);

    logic                     flush;
    logic [RAM_WIDTH-1:0]     in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [RAM_WIDTH-1:0]     out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LEVEL_BITS-1:0]    level;
    logic [RAM_ADDR_BITS-1:0] ram_write_address;
    logic                     ram_write_enable;
    logic [RAM_WIDTH-1:0]     ram_data_in;
    logic [RAM_ADDR_BITS-1:0] ram_read_address;
    logic [RAM_WIDTH-1:0]     ram_data_out;

    modport slave (
        input  flush, in_data, in_valid, out_ready, ram_data_out,
        output in_ready, out_data, out_valid, level,
               ram_write_address, ram_write_enable, ram_data_in, ram_read_address
    );

    modport master (
        output flush, in_data, in_valid, out_ready, ram_data_out,
        input  in_ready, out_data, out_valid, level,
               ram_write_address, ram_write_enable, ram_data_in, ram_read_address
    );

endinterface
`default_nettype wire

// File: rtl/ram_fifo_skid.sv
`default_nettype none
// ==========================================================================
// ram_fifo_skid : 2-entry register FIFO whose head drives the output, rev 1.0
// ==========================================================================
module ram_fifo_skid
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  head_valid,
    output logic [1:0]            count
);

    skid_state_t      state;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SKID_EMPTY;
            slot0      <= '0;
            slot1      <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            state      <= SKID_EMPTY;
            head_valid <= 1'b0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (push) begin
                        slot0      <= push_data;
                        state      <= SKID_ONE;
                        head_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        slot0 <= push_data;
                    end else if (push) begin
                        slot1 <= push_data;
                        state <= SKID_TWO;
                    end else if (pop) begin
                        state      <= SKID_EMPTY;
                        head_valid <= 1'b0;
                    end
                end
                SKID_TWO: begin
                    // The controller never pushes into a full buffer without a pop.
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) begin
                            slot1 <= push_data;
                        end else begin
                            state <= SKID_ONE;
                        end
                    end
                end
                default: begin
                    state      <= SKID_EMPTY;
                    head_valid <= 1'b0;
                end
            endcase
        end
    end

    assign head_data = slot0;
    assign count     = state;

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ==========================================================================
// ram_fifo_ctrl : streaming FIFO sequencer around a dual-port RAM, rev 1.0
// ==========================================================================
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
    input  wire logic      clock,
    input  wire logic      reset_n,
    ram_fifo_ctrl_if.slave bus
);

    localparam int PTR_BITS   = ptr_bits(RAM_ADDR_BITS);
    localparam int LEVEL_BITS = level_bits(RAM_ADDR_BITS);
    localparam logic [PTR_BITS-1:0] DEPTH = {1'b1, {RAM_ADDR_BITS{1'b0}}};

    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   ram_occ;
    logic                  rd_pending;
    logic [LEVEL_BITS-1:0] level_count;
    logic                  ram_full;
    logic                  accept;
    logic                  write_en;
    logic                  pop;
    logic                  rd_issue;
    logic [1:0]            skid_count;
    logic [2:0]            skid_demand;
    logic                  skid_valid;
    logic [RAM_WIDTH-1:0]  skid_data;

    assign ram_occ  = wr_ptr - rd_ptr;
    assign ram_full = (ram_occ == DEPTH);
    assign accept   = !ram_full && !bus.flush;
    assign write_en = bus.in_valid && accept;
    assign pop      = skid_valid && bus.out_ready;

    // Words the skid will hold next cycle if no new read is issued now.
    assign skid_demand = {1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign rd_issue    = (ram_occ != '0) && (skid_demand < 3'd2) && !bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_pending  <= 1'b0;
            level_count <= '0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_pending  <= 1'b0;
            level_count <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            rd_pending  <= rd_issue;
            level_count <= level_count + {{(LEVEL_BITS-1){1'b0}}, write_en}
                                       - {{(LEVEL_BITS-1){1'b0}}, pop};
        end
    end

    // In-flight RAM data is dropped on flush by gating the push.
    ram_fifo_skid #(
        .WIDTH (RAM_WIDTH)
    ) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (bus.flush),
        .push       (rd_pending && !bus.flush),
        .push_data  (bus.ram_data_out),
        .pop        (pop),
        .head_data  (skid_data),
        .head_valid (skid_valid),
        .count      (skid_count)
    );

    assign bus.in_ready          = accept;
    assign bus.out_data          = skid_data;
    assign bus.out_valid         = skid_valid;
    assign bus.level             = level_count;
    assign bus.ram_write_address = wr_ptr[RAM_ADDR_BITS-1:0];
    assign bus.ram_write_enable  = write_en;
    assign bus.ram_data_in       = bus.in_data;
    assign bus.ram_read_address  = rd_ptr[RAM_ADDR_BITS-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_ram_fifo_ctrl : table vectors plus queue reference model, rev 1.0
// ==========================================================================
module tb_ram_fifo_ctrl;

    localparam int W  = 8;
    localparam int A  = 4;
    localparam int D  = 16;
    localparam int LW = A + 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ram_fifo_ctrl_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

    ram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural dual-port RAM with registered read.
    logic [W-1:0] ram_mem [D];
    always @(posedge clock) begin
        if (bus.ram_write_enable) ram_mem[bus.ram_write_address] <= bus.ram_data_in;
        bus.ram_data_out <= ram_mem[bus.ram_read_address];
    end

    typedef struct {
        logic [W-1:0] data;
        int           edge_no;
    } entry_t;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          exp_rdy;
        logic          exp_ov;
        logic [W-1:0]  exp_dat;
        logic [LW-1:0] exp_lvl;
    } vec_t;

    entry_t       model_q[$];
    vec_t         tbl[15];
    vec_t         tbl_cur;
    bit           tbl_en = 1'b0;
    int           tbl_row = 0;
    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    bit           last_wr, last_pop, prev_stall = 1'b0;
    logic [W-1:0] prev_data, last_pop_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A word accepted at edge e is at the output from edge e+2 until popped.
    task automatic check_model();
        bit exp_ov;
        exp_ov = 1'b0;
        if (model_q.size() > 0) exp_ov = (cyc >= model_q[0].edge_no + 2);
        chk("level", bus.level, model_q.size());
        chk("out_valid", bus.out_valid, exp_ov);
        if (exp_ov && bus.out_valid) chk("out_data", bus.out_data, model_q[0].data);
        if (model_q.size() < D) chk("in_ready", bus.in_ready, !bus.flush);
        else if (model_q.size() == D + 2) chk("in_ready_full", bus.in_ready, 0);
        if (prev_stall && bus.out_valid) chk("stall_hold", bus.out_data, prev_data);
        prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
        prev_data  = bus.out_data;
    endtask

    task automatic check_row();
        logic [W-1:0] act_d, exp_d;
        act_d = tbl_cur.exp_ov ? bus.out_data : '0;
        exp_d = tbl_cur.exp_ov ? tbl_cur.exp_dat : '0;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.level, act_d} !==
            {tbl_cur.exp_rdy, tbl_cur.exp_ov, tbl_cur.exp_lvl, exp_d}) begin
            miscompares++;
            $display("FAIL row%0d: got rdy=%b ov=%b lvl=%0d dat=%h, need rdy=%b ov=%b lvl=%0d dat=%h",
                     tbl_row, bus.in_ready, bus.out_valid, bus.level, act_d,
                     tbl_cur.exp_rdy, tbl_cur.exp_ov, tbl_cur.exp_lvl, exp_d);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(negedge clock);
        check_model();
        if (tbl_en) check_row();
        last_wr       = bus.in_valid && bus.in_ready;
        last_pop      = bus.out_valid && bus.out_ready;
        last_pop_data = bus.out_data;
        @(posedge clock);
        cyc++;
        if (fl) begin
            model_q.delete();
        end else begin
            if (last_pop && model_q.size() > 0) void'(model_q.pop_front());
            if (last_wr) model_q.push_back('{data: d, edge_no: cyc});
        end
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (model_q.size() > 0 && n < 60) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        chk({name, "_drained"}, model_q.size(), 0);
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_out_valid"}, bus.out_valid, 0);
        chk({name, "_level"}, bus.level, 0);
        chk({name, "_in_ready"}, bus.in_ready, 1);
        chk({name, "_wr_en"}, bus.ram_write_enable, 0);
        chk({name, "_waddr"}, bus.ram_write_address, 0);
        chk({name, "_raddr"}, bus.ram_read_address, 0);
    endtask

    task automatic mid_reset();
        #2;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_values("midrst");
        model_q.delete();
        prev_stall = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc, pops, maxl, first_out;
        bit           got_first;
        logic [W-1:0] nxt;

        for (int i = 0; i < D; i++) ram_mem[i] = '0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(posedge clock);
        cyc++;
        #1;

        // fl iv d ordy | rdy ov dat lvl
        tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 6'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd0};
        tbl[6]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 6'd0};
        tbl[7]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, 6'd1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd2};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 6'd2};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3, 6'd1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd0};
        tbl[12] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0};
        tbl[13] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0};
        tbl_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tbl_row = i;
            tbl_cur = tbl[i];
            step(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
        end
        tbl_en = 1'b0;

        // Fill to 18 words with the consumer stalled, then drain including the stalled 19th.
        acc = 0; nxt = '0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, nxt, 1'b0);
            if (last_wr) begin acc++; nxt++; end
        end
        chk("fill_accepted", acc, 18);
        chk("fill_level", bus.level, 18);
        chk("fill_in_ready", bus.in_ready, 0);
        pops = 0;
        for (int i = 0; i < 60 && (acc < 19 || model_q.size() > 0); i++) begin
            step(1'b0, acc < 19, nxt, 1'b1);
            if (last_wr) begin acc++; nxt++; end
            if (last_pop) pops++;
        end
        chk("fill_popped", pops, 19);

        // Full-rate streaming.
        acc = 0; pops = 0; maxl = 0;
        for (int i = 0; i < 140 && pops < 100; i++) begin
            step(1'b0, acc < 100, 8'(acc), 1'b1);
            if (last_wr) acc++;
            if (last_pop) pops++;
            if (int'(bus.level) > maxl) maxl = int'(bus.level);
        end
        chk("stream_pops", pops, 100);
        chk("stream_max_level_le3", maxl <= 3, 1);

        // Random bursts across pointer wrap.
        acc = 0; pops = 0;
        for (int i = 0; i < 600 && pops < 40; i++) begin
            step(1'b0, (acc < 40) && ((i / 5) % 2 == 0 || $urandom_range(3, 0) == 0),
                 8'($urandom), $urandom_range(2, 0) != 0);
            if (last_wr) acc++;
            if (last_pop) pops++;
        end
        chk("wrap_pops", pops, 40);

        // Random backpressure.
        acc = 0; pops = 0;
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'($urandom_range(1, 0)));
            if (last_wr) acc++;
            if (last_pop) pops++;
        end
        for (int i = 0; i < 60 && model_q.size() > 0; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (last_pop) pops++;
        end
        chk("bp_no_drop", pops, acc);

        // Flush at level 10, then the next write must be the next output.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        chk("pre_flush_level", bus.level, 10);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("flush_level", bus.level, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        got_first = 1'b0; first_out = -1;
        for (int i = 0; i < 20 && model_q.size() > 0; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (last_pop && !got_first) begin got_first = 1'b1; first_out = int'(last_pop_data); end
        end
        chk("flush_first_out", first_out, 32'h3C);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom), 1'($urandom_range(1, 0)));
        mid_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b1);
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
